fetch_stage: RTL and testbench

//  PC generator and IF/ID pipeline register for the 22-bit core. It drives a byte address to the

---
 rtl/core_pkg.sv | 18 +
 rtl/if_id_reg.sv | 48 ++++
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Types and constants shared by the fetch and decode stages of the 22-bit core.
package core_pkg;
    localparam int WORD_W = 22;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam word_t BUBBLE_INSTR = 22'h000000;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return addr & 22'h3FFFFC;
    endfunction
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds, loads a fetched instruction, or loads a bubble.
module if_id_reg
    import core_pkg::*;
#(
    parameter logic [WORD_W-1:0] BUBBLE = BUBBLE_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic [WORD_W-1:0] instr_i,
    input  logic [WORD_W-1:0] pc_i,
    input  logic [WORD_W-1:0] pc4_i,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] pc_o,
    output logic [WORD_W-1:0] pc4_o,
    output logic              valid_o
);
    logic [WORD_W-1:0] instr_q, pc_q, pc4_q;
    logic              valid_q;

    // Bubble loads never look at instr_i, so an undriven memory word stays out of valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= BUBBLE;
            pc_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            if (bubble_i) begin
                instr_q <= BUBBLE;
                pc_q    <= '0;
                pc4_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                instr_q <= instr_i;
                pc_q    <= pc_i;
                pc4_q   <= pc4_i;
                valid_q <= 1'b1;
            end
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// PC generator, RUN/HALT fetch FSM and fetch counter; feeds the IF/ID register.
// States: RUN = fetching sequentially | HALT = end of program reached, bubbles only.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 22'h000000,
    parameter logic [WORD_W-1:0] END_PC   = 22'd400,
    parameter logic [WORD_W-1:0] BUBBLE   = BUBBLE_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] if_id_instr,
    output logic [WORD_W-1:0] if_id_pc,
    output logic [WORD_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic              halted,
    output logic [15:0]       fetch_count
);
    fetch_state_t      state_q;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] target;
    logic              halted_q;
    logic [15:0]       count_q;
    logic              ifid_load, ifid_bubble, fetch_ok;

    assign pc_plus4  = pc_q + 22'd4;
    assign target    = align_word(branch_target);
    assign imem_addr = pc_q;

    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        fetch_ok    = 1'b0;
        if (branch_taken || state_q == HALT || flush) begin
            ifid_load   = 1'b1;
            ifid_bubble = 1'b1;
        end else if (!stall) begin
            ifid_load = 1'b1;
            fetch_ok  = 1'b1;
        end
    end

    // On the halting edge the PC stays on the last word instead of stepping past the program.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (branch_taken) begin
                pc_q <= target;
                if (target >= END_PC) begin
                    state_q  <= HALT;
                    halted_q <= 1'b1;
                end else begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            end else if (state_q == RUN && !stall) begin
                if (pc_plus4 >= END_PC) begin
                    state_q  <= HALT;
                    halted_q <= 1'b1;
                end else begin
                    pc_q <= pc_plus4;
                end
            end
            if (fetch_ok && count_q != 16'hFFFF) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    if_id_reg #(
        .BUBBLE(BUBBLE)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifid_load),
        .bubble_i(ifid_bubble),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .pc4_i   (pc_plus4),
        .instr_o (if_id_instr),
        .pc_o    (if_id_pc),
        .pc4_o   (if_id_pc4),
        .valid_o (if_id_valid)
    );

    assign halted      = halted_q;
    assign fetch_count = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed check of fetch_stage against a behavioural fetch model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
    logic [21:0] branch_target = '0;
    logic [21:0] imem_addr, imem_rdata;
    logic [21:0] if_id_instr, if_id_pc, if_id_pc4;
    logic        if_id_valid, halted;
    logic [15:0] fetch_count;

    logic [21:0] mem [0:1023];
    logic        junk = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    logic [21:0] m_pc, m_instr, m_ifpc, m_ifpc4;
    logic        m_valid, m_halt;
    int          m_count;

    localparam logic [21:0] END_PC = 22'd400;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    // Garbage on the read port whenever the word must not be captured.
    assign imem_rdata = junk ? 22'h2AAAAA : mem[imem_addr[11:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 22'h0; m_instr = 22'h0; m_ifpc = 22'h0; m_ifpc4 = 22'h0;
        m_valid = 1'b0; m_halt = 1'b0; m_count = 0;
    endtask

    task automatic model_step(input logic st, input logic fl, input logic br, input logic [21:0] tgt);
        logic [21:0] nxt;
        nxt  = m_pc + 22'd4;
        junk = 1'b1;
        if (br) begin
            m_pc    = {tgt[21:2], 2'b00};
            m_halt  = (m_pc >= END_PC);
            m_valid = 1'b0; m_instr = 22'h0; m_ifpc = 22'h0; m_ifpc4 = 22'h0;
        end else if (m_halt) begin
            m_valid = 1'b0; m_instr = 22'h0; m_ifpc = 22'h0; m_ifpc4 = 22'h0;
        end else if (fl) begin
            m_valid = 1'b0; m_instr = 22'h0; m_ifpc = 22'h0; m_ifpc4 = 22'h0;
            if (!st) begin
                if (nxt >= END_PC) m_halt = 1'b1;
                else m_pc = nxt;
            end
        end else if (!st) begin
            junk    = 1'b0;
            m_valid = 1'b1;
            m_instr = mem[m_pc[11:2]];
            m_ifpc  = m_pc;
            m_ifpc4 = nxt;
            if (m_count < 65535) m_count++;
            if (nxt >= END_PC) m_halt = 1'b1;
            else m_pc = nxt;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},   imem_addr,   m_pc);
        chk({tag, ".valid"},  if_id_valid, m_valid);
        chk({tag, ".instr"},  if_id_instr, m_instr);
        chk({tag, ".halted"}, halted,      m_halt);
        chk({tag, ".count"},  fetch_count, m_count);
        if (m_valid) begin
            chk({tag, ".pc"},  if_id_pc,  m_ifpc);
            chk({tag, ".pc4"}, if_id_pc4, m_ifpc4);
        end
    endtask

    // Called just after a rising edge: drive, predict, step one edge, compare.
    task automatic cyc(input logic st, input logic fl, input logic br, input logic [21:0] tgt,
                       input string tag);
        stall = st; flush = fl; branch_taken = br; branch_target = tgt;
        model_step(st, fl, br, tgt);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
        @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        int saved;
        for (int i = 0; i < 1024; i++) mem[i] = 22'($urandom);

        // 1: free run from reset
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, "t1");
        chk("t1_count", fetch_count, 4);
        chk("t1_addr", imem_addr, 16);
        chk("t1_pc", if_id_pc, 12);
        chk("t1_word3", if_id_instr, mem[3]);

        // 2: stall at PC=8
        do_reset();
        cyc(0, 0, 0, 0, "t2"); cyc(0, 0, 0, 0, "t2");
        cyc(1, 0, 0, 0, "t2s"); cyc(1, 0, 0, 0, "t2s");
        chk("t2_hold_addr", imem_addr, 8);
        chk("t2_hold_pc", if_id_pc, 4);
        chk("t2_hold_word", if_id_instr, mem[1]);
        cyc(0, 0, 0, 0, "t2r");
        chk("t2_resume_pc", if_id_pc, 8);

        // 3: branch overrides stall, low bits dropped
        cyc(1, 0, 1, 22'h00002D, "t3b");
        chk("t3_addr", imem_addr, 22'h2C);
        chk("t3_valid", if_id_valid, 0);
        cyc(0, 0, 0, 0, "t3f");
        chk("t3_pc", if_id_pc, 22'h2C);
        chk("t3_word", if_id_instr, mem[11]);

        // 4: end of program and restart
        cyc(0, 0, 1, 22'd388, "t4b");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, "t4");
        chk("t4_last_pc", if_id_pc, 396);
        chk("t4_last_valid", if_id_valid, 1);
        chk("t4_halted", halted, 1);
        chk("t4_pc_hold", imem_addr, 396);
        cyc(0, 0, 0, 0, "t4h");
        chk("t4_bubble", if_id_valid, 0);
        cyc(0, 0, 1, 22'd0, "t4r");
        chk("t4_run", halted, 0);

        // 5: flush alone at PC=20
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, "t5");
        chk("t5_at20", imem_addr, 20);
        saved = m_count;
        cyc(0, 1, 0, 0, "t5f");
        chk("t5_valid", if_id_valid, 0);
        chk("t5_addr", imem_addr, 24);
        chk("t5_count", fetch_count, saved);

        // 6: asynchronous reset mid-cycle at PC=40
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, "t6");
        chk("t6_at40", imem_addr, 40);
        #2 rst = 1'b1;
        #1;
        chk("t6_addr", imem_addr, 0);
        chk("t6_valid", if_id_valid, 0);
        chk("t6_count", fetch_count, 0);
        chk("t6_halted", halted, 0);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        st, fl, br;
            logic [21:0] tgt;
            st = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 10);
            br = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 9) < 8) tgt = 22'($urandom_range(0, 420));
            else tgt = 22'($urandom);
            cyc(st, fl, br, tgt, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
